// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared constants, selector and state encodings for the servo PWM generator
package servo_pkg;

    localparam int default_period_c   = 1_000_000;
    localparam int default_duty_0_c   = 24999;
    localparam int default_duty_90_c  = 74999;
    localparam int default_duty_180_c = 124999;
    localparam int default_debounce_c = 500_000;

    localparam int data_length_p = 17;
    localparam int per_width_c   = 20;

    typedef enum logic [1:0] {
        SEL_OFF = 2'b00,
        SEL_0   = 2'b01,
        SEL_90  = 2'b10,
        SEL_180 = 2'b11
    } sel_e;

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } state_e;

endpackage

// File: rtl/sel_debounce.sv
// rtl/sel_debounce.sv - two-flop synchroniser and stability debouncer for the angle selector
module sel_debounce
    import servo_pkg::*;
#(
    parameter int width_p    = 2,
    parameter int debounce_p = default_debounce_c
) (
    input  logic               Clk_i,
    input  logic               Reset_i,
    input  logic [width_p-1:0] Sel_i,
    output logic [width_p-1:0] Stable_o
);

    localparam int                 cnt_w_c   = (debounce_p > 1) ? $clog2(debounce_p) : 1;
    localparam logic [cnt_w_c-1:0] cnt_max_c = cnt_w_c'(debounce_p - 1);

    logic [width_p-1:0] meta_r;
    logic [width_p-1:0] sync_sel;
    logic [width_p-1:0] cand_r;
    logic [width_p-1:0] stable_sel_r;
    logic [cnt_w_c-1:0] cnt_r;

    // bring the raw selector into the clock domain
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            meta_r   <= '0;
            sync_sel <= '0;
        end else begin
            meta_r   <= Sel_i;
            sync_sel <= meta_r;
        end
    end

    // accept a candidate only after it has held for debounce_p cycles
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            cand_r       <= '0;
            cnt_r        <= '0;
            stable_sel_r <= '0;
        end else if (sync_sel != cand_r) begin
            cand_r <= sync_sel;
            cnt_r  <= '0;
        end else if (cand_r != stable_sel_r) begin
            if (cnt_r == cnt_max_c) begin
                stable_sel_r <= cand_r;
                cnt_r        <= '0;
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
        end else begin
            cnt_r <= '0;
        end
    end

    assign Stable_o = stable_sel_r;

endmodule

// File: rtl/servo_pwm_gen.sv
// rtl/servo_pwm_gen.sv - 50 Hz servo PWM with period-aligned duty updates and reporter handoff
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int period_p   = default_period_c,
    parameter int duty_0_p   = default_duty_0_c,
    parameter int duty_90_p  = default_duty_90_c,
    parameter int duty_180_p = default_duty_180_c,
    parameter int debounce_p = default_debounce_c
) (
    input  logic                     Clk_i,
    input  logic                     Reset_i,
    input  logic [1:0]               Sel_i,
    output logic                     Pwm_o,
    output logic [data_length_p-1:0] Data_o,
    output logic                     Enable_o
);

    // compare is done at the wider of the two operands so no bits are dropped
    localparam int cmp_w_c = (data_length_p > per_width_c) ? data_length_p : per_width_c;

    localparam logic [data_length_p-1:0] duty_0_c   = data_length_p'(duty_0_p);
    localparam logic [data_length_p-1:0] duty_90_c  = data_length_p'(duty_90_p);
    localparam logic [data_length_p-1:0] duty_180_c = data_length_p'(duty_180_p);
    localparam logic [per_width_c-1:0]   wrap_c     = per_width_c'(period_p - 1);

    logic [1:0]               stable_sel;
    logic [data_length_p-1:0] sel_duty;
    logic [data_length_p-1:0] duty_r;
    logic [per_width_c-1:0]   per_r;
    logic [cmp_w_c-1:0]       per_ext;
    logic [cmp_w_c-1:0]       duty_ext;
    logic                     wrap;
    logic                     pwm_r;
    logic                     enable_r;
    state_e                   state_r;

    sel_debounce #(
        .width_p    (2),
        .debounce_p (debounce_p)
    ) u_sel_debounce (
        .Clk_i    (Clk_i),
        .Reset_i  (Reset_i),
        .Sel_i    (Sel_i),
        .Stable_o (stable_sel)
    );

    // map the accepted selector to its compare value; off selects zero
    always_comb begin
        sel_duty = '0;
        case (stable_sel)
            SEL_0:   sel_duty = duty_0_c;
            SEL_90:  sel_duty = duty_90_c;
            SEL_180: sel_duty = duty_180_c;
            default: sel_duty = '0;
        endcase
    end

    assign per_ext  = cmp_w_c'(per_r);
    assign duty_ext = cmp_w_c'(duty_r);
    assign wrap     = (per_r == wrap_c);

    // OFF/RUN sequencing, period counter and registered pulse; duty only moves at wrap
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_r  <= ST_OFF;
            per_r    <= '0;
            duty_r   <= '0;
            pwm_r    <= 1'b0;
            enable_r <= 1'b0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    per_r <= '0;
                    pwm_r <= 1'b0;
                    if (stable_sel != SEL_OFF) begin
                        duty_r   <= sel_duty;
                        enable_r <= 1'b1;
                        state_r  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    pwm_r <= (per_ext <= duty_ext);
                    if (wrap) begin
                        per_r <= '0;
                        if (stable_sel == SEL_OFF) begin
                            duty_r   <= '0;
                            enable_r <= 1'b0;
                            state_r  <= ST_OFF;
                        end else begin
                            duty_r <= sel_duty;
                        end
                    end else begin
                        per_r <= per_r + 1'b1;
                    end
                end
                default: state_r <= ST_OFF;
            endcase
        end
    end

    assign Pwm_o    = pwm_r;
    assign Data_o   = duty_r;
    assign Enable_o = enable_r;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb/tb_servo_pwm_gen.sv - directed self-checking bench for servo_pwm_gen at reduced timing
module tb_servo_pwm_gen;

    localparam int per_c  = 100;
    localparam int d0_c   = 9;
    localparam int d90_c  = 29;
    localparam int d180_c = 49;
    localparam int deb_c  = 20;
    localparam int lo_bound_c = 3 * per_c;

    logic        Clk_i = 1'b0;
    logic        Reset_i;
    logic [1:0]  Sel_i;
    logic        Pwm_o;
    logic [16:0] Data_o;
    logic        Enable_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk_i = ~Clk_i;

    servo_pwm_gen #(
        .period_p   (per_c),
        .duty_0_p   (d0_c),
        .duty_90_p  (d90_c),
        .duty_180_p (d180_c),
        .debounce_p (deb_c)
    ) dut (
        .Clk_i    (Clk_i),
        .Reset_i  (Reset_i),
        .Sel_i    (Sel_i),
        .Pwm_o    (Pwm_o),
        .Data_o   (Data_o),
        .Enable_o (Enable_o)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk_i);
        #1;
    endtask

    task automatic wait_enable(output int n);
        n = 0;
        while (!Enable_o && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_rise(output int seen);
        logic prev;
        seen = 0;
        prev = Pwm_o;
        for (int i = 0; i < lo_bound_c; i++) begin
            tick();
            if (Pwm_o && !prev) begin
                seen = 1;
                return;
            end
            prev = Pwm_o;
        end
    endtask

    // starts on a rise cycle; ends on the next rise cycle (or after lo_bound_c low cycles)
    task automatic measure(output int hi, output int lo, output int chg, output int chg_at);
        logic [16:0] last;
        int off;
        hi = 0; lo = 0; chg = 0; chg_at = -1; off = 0;
        last = Data_o;
        while (Pwm_o && hi < lo_bound_c) begin
            hi++;
            tick();
            off++;
            if (Data_o != last) begin chg++; chg_at = off; last = Data_o; end
        end
        while (!Pwm_o && lo < lo_bound_c) begin
            lo++;
            tick();
            off++;
            if (Data_o != last) begin chg++; chg_at = off; last = Data_o; end
        end
    endtask

    initial begin
        int n, hi, lo, chg, at, seen;
        logic [16:0] last;

        Reset_i = 1'b1;
        Sel_i   = 2'b00;
        repeat (3) tick();
        Reset_i = 1'b0;
        tick();
        check_eq("reset_pwm", Pwm_o, 0);
        check_eq("reset_data", Data_o, 0);
        check_eq("reset_enable", Enable_o, 0);

        // short glitch on the selector must never start a pulse train
        seen = 0;
        Sel_i = 2'b01;
        repeat (deb_c - 4) begin tick(); if (Enable_o || Pwm_o) seen = 1; end
        Sel_i = 2'b00;
        repeat (60) begin tick(); if (Enable_o || Pwm_o) seen = 1; end
        check_eq("glitch_no_run", seen, 0);
        check_eq("glitch_data", Data_o, 0);

        // start at 90 degrees from OFF
        Sel_i = 2'b10;
        wait_enable(n);
        check_eq("start_latency", n, deb_c + 4);
        check_eq("start_data", Data_o, d90_c);
        check_eq("start_pwm_low", Pwm_o, 0);
        tick();
        check_eq("first_rise", Pwm_o, 1);
        measure(hi, lo, chg, at);
        check_eq("p90_high", hi, d90_c + 1);
        check_eq("p90_low", lo, per_c - d90_c - 1);
        check_eq("p90_data_steady", chg, 0);

        // change to 0 degrees right at a rise: current pulse keeps its width
        Sel_i = 2'b01;
        measure(hi, lo, chg, at);
        check_eq("p90to0_high", hi, d90_c + 1);
        check_eq("p90to0_low", lo, per_c - d90_c - 1);
        check_eq("p90to0_chg_at", at, per_c - 1);
        check_eq("p0_data", Data_o, d0_c);

        // running at 0 degrees, move to 180 mid-period
        fork
            measure(hi, lo, chg, at);
            begin repeat (30) tick(); Sel_i = 2'b11; end
        join
        check_eq("p0to180_high", hi, d0_c + 1);
        check_eq("p0to180_low", lo, per_c - d0_c - 1);
        check_eq("p0to180_chg", chg, 1);
        check_eq("p0to180_chg_at", at, per_c - 1);
        measure(hi, lo, chg, at);
        check_eq("p180_high", hi, d180_c + 1);
        check_eq("p180_low", lo, per_c - d180_c - 1);
        check_eq("p180_data", Data_o, d180_c);

        // switch off during a 180 period: finishes the period then drops out
        fork
            measure(hi, lo, chg, at);
            begin repeat (60) tick(); Sel_i = 2'b00; end
        join
        check_eq("off_high", hi, d180_c + 1);
        check_eq("off_stays_low", lo, lo_bound_c);
        check_eq("off_chg_at", at, per_c - 1);
        check_eq("off_data", Data_o, 0);
        check_eq("off_enable", Enable_o, 0);

        // bouncing selector settles at 180: exactly one Data_o change
        chg = 0;
        last = Data_o;
        for (int i = 0; i < 12; i++) begin
            Sel_i = (i % 2 == 0) ? 2'b01 : 2'b11;
            repeat (10) begin tick(); if (Data_o != last) begin chg++; last = Data_o; end end
        end
        Sel_i = 2'b11;
        repeat (60) begin tick(); if (Data_o != last) begin chg++; last = Data_o; end end
        check_eq("bounce_chg", chg, 1);
        check_eq("bounce_data", Data_o, d180_c);
        check_eq("bounce_enable", Enable_o, 1);

        // reset in the middle of a 90 degree pulse
        Sel_i = 2'b10;
        n = 0;
        while (Data_o != 17'(d90_c) && n < lo_bound_c) begin tick(); n++; end
        check_eq("pre_reset_data", Data_o, d90_c);
        wait_rise(seen);
        check_eq("pre_reset_rise", seen, 1);
        repeat (5) tick();
        check_eq("pre_reset_pwm", Pwm_o, 1);
        #3 Reset_i = 1'b1;
        #1;
        check_eq("async_reset_pwm", Pwm_o, 0);
        check_eq("async_reset_data", Data_o, 0);
        check_eq("async_reset_enable", Enable_o, 0);
        tick();
        Reset_i = 1'b0;
        wait_enable(n);
        check_eq("restart_latency", n, deb_c + 4);
        check_eq("restart_data", Data_o, d90_c);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/servo_pwm_gen.md
# servo_pwm_gen

Generates the 50 Hz servo drive waveform for the MG995 from a 2-bit angle selector, such as board switches or buttons.
- Synchronises and debounces the selector.
- Latches the new pulse width only on a PWM period boundary.
- Publishes the active compare value and an enable on `Data_o`/`Enable_o`. These feed the downstream UART angle reporter on its `Data_i`/`Enable_i`.
- Sits directly upstream of the UART reporter. `Pwm_o` drives the servo signal pin.

## Interface
- `period_p`, 1_000_000 — PWM period in clock cycles (20 ms at 50 MHz).
- `duty_0_p`, 24999 — compare value for 0° (0.5 ms high).
- `duty_90_p`, 74999 — compare value for 90° (1.5 ms high).
- `duty_180_p`, 124999 — compare value for 180° (2.5 ms high).
- `debounce_p`, 500_000 — cycles the selector must be stable before acceptance (10 ms).
- `data_length_p`, 17 — width of the compare value.

Ports:
- `Clk_i`  in  1  system clock, 50 MHz.
- `Reset_i`  in  1  reset; one clock; asynchronous, active-high.
- `Sel_i`  in  2  raw asynchronous selector:
  - 00 off
  - 01 0°
  - 10 90°
  - 11 180°
- `Pwm_o`  out  1  servo pulse.
- `Data_o`  out  17  active compare value; 0 when off.
- `Enable_o`  out  1  high while a pulse train is running.

## Operation
Selector path:
- `Sel_i` passes through a 2-flop synchroniser to give `sync_sel`.
- Debouncer holds `cand_r`, `cnt_r` and `stable_sel_r`:
  - If `sync_sel != cand_r`: `cand_r <= sync_sel`, `cnt_r <= 0`.
  - Else, if `cand_r != stable_sel_r`: `cnt_r` increments. When `cnt_r == debounce_p-1`, `stable_sel_r <= cand_r` and `cnt_r <= 0`.
  - Else `cnt_r <= 0`.
- Glitches shorter than `debounce_p` cycles never reach `stable_sel_r`.

Period counter `per_r` (20 bits):
- Counts 0 … `period_p-1`, then wraps to 0.
- Held at 0 in OFF.
- "Wrap" means the cycle where `per_r == period_p-1`.

Duty select, combinational from `stable_sel_r`:
- 01 → `duty_0_p`
- 10 → `duty_90_p`
- 11 → `duty_180_p`
- 00 → 0 (off)

FSM, states OFF and RUN:
- OFF:
  - `Pwm_o = 0`, `Data_o = 0`, `Enable_o = 0`.
  - When `stable_sel_r != 00`: `duty_r` loads the selected value, go to RUN. `per_r` starts at 0 on the next cycle.
- RUN:
  - `Pwm_o` is registered: high when `per_r <= duty_r`, so exactly `duty_r+1` cycles high per period.
  - At wrap with `stable_sel_r == 00`: go to OFF and clear `duty_r`.
  - At wrap otherwise: `duty_r` loads the selected value, which may be unchanged.
  - A selection change mid-period never alters the current pulse.
- `Data_o = duty_r`; `Enable_o = 1` in RUN.

Boundary conditions:
- Acceptance of a new value on the wrap cycle itself is applied at that wrap; the registered selector is used.
- Reset mid-period: all outputs go low immediately and the FSM returns to OFF.
- `duty_r >= period_p` cannot occur with the defaults. No guard is required, but the compare must be full-width unsigned.

## Timing
- Reset values:
  - `Pwm_o = 0`, `Data_o = 0`, `Enable_o = 0`
  - `stable_sel_r = 00`, `cand_r = 00`, `cnt_r = 0`, `per_r = 0`, state OFF.
- Selector acceptance latency: 2 synchroniser cycles + 1 (`cand_r` load) + `debounce_p` cycles from the `Sel_i` edge to the `stable_sel_r` update.
- From OFF:
  - The first `Pwm_o` rise comes 2 cycles after `stable_sel_r` changes.
  - `Data_o` and `Enable_o` are valid 1 cycle after `stable_sel_r` changes.
- In RUN, new `Data_o` appears on the cycle after wrap, aligned with `per_r = 0`. `Data_o` changes at most once per period, which guarantees the downstream reporter sees a stable value.
- `Pwm_o` is registered, with one cycle of latency from the `per_r` compare.

## Structure
- Shared package `servo_pkg`:
  - default period, duty and debounce constants
  - selector encodings (`SEL_OFF`, `SEL_0`, `SEL_90`, `SEL_180`)
  - FSM state encoding
  - `data_length_p`
- Sub-module `sel_debounce`: synchroniser plus debouncer, parameterised by width and `debounce_p`; outputs `stable_sel_r`.
- Top level: period counter, FSM, compare.

## Test plan
- Reset then `Sel_i = 10` held: `Enable_o` rises 2+1+500000+1 cycles after the edge. `Data_o = 74999`. `Pwm_o` is high 75000 cycles then low 925000 cycles, repeating.
- `Sel_i = 01` pulsed for 400000 cycles, then back to 00: `stable_sel_r` unchanged, `Pwm_o` stays 0, `Enable_o` stays 0.
- Running at 0°, `Sel_i` changes to 11 at `per_r ≈ 300000`:
  - The current period completes with 25000 high cycles.
  - `Data_o` becomes 124999 exactly at the first wrap after acceptance.
  - The next pulse is 125000 cycles.
- Running at 180°, `Sel_i` changes to 00: the in-flight period finishes. At wrap, `Enable_o` and `Data_o` drop to 0 and `Pwm_o` stays low.
- Selector toggles 01↔11 every 1000 cycles for 2 ms, then settles at 11: exactly one `Data_o` change, to 124999.
- `Reset_i` asserted mid-pulse (`per_r = 10000`): `Pwm_o`, `Data_o` and `Enable_o` go to 0 asynchronously. After release with `Sel_i = 10` still held, normal start-up recurs after the full debounce latency.
